// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline register.
// Control field layout, ID/EX payload offsets and a width helper.
package pipe_pkg;

  localparam int EX_W   = 4;
  localparam int MEM_W  = 2;
  localparam int WB_W   = 2;
  localparam int EX_LSB  = 0;
  localparam int MEM_LSB = EX_LSB + EX_W;
  localparam int WB_LSB  = MEM_LSB + MEM_W;
  localparam int CTRL_W_DEF = WB_LSB + WB_W;

  localparam int PC_LSB     = 0;
  localparam int RS_D_LSB   = 32;
  localparam int RT_D_LSB   = 64;
  localparam int SEIMM_LSB  = 96;
  localparam int RS_A_LSB   = 112;
  localparam int RT_A_LSB   = 117;
  localparam int RD_A_LSB   = 122;
  localparam int DATA_W_DEF = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1)
      r++;
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready bundle carrying one control field and one payload.
// master drives valid/ctrl/data; slave drives ready.
interface pipe_stage_elastic_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
);

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output ctrl,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  ctrl,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_slot.sv
// One pipeline slot: valid, control and payload registers.
// Control is forced to zero whenever the slot holds no instruction.
module pipe_slot #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              src_valid,
  input  logic [CTRL_W-1:0] src_ctrl,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      // payload is left as-is on a squash
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= src_valid;
      ctrl  <= src_valid ? src_ctrl : '0;
      data  <= src_data;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic DEPTH-slot pipeline register with bubble collapsing,
// global freeze and synchronous squash.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 1,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  pipe_stage_elastic_if.slave  up,
  pipe_stage_elastic_if.master dn,
  output logic [CNT_W-1:0]  count
);

  logic [DEPTH:0]    adv;
  logic [DEPTH-1:0]  v;
  logic [CTRL_W-1:0] c [DEPTH];
  logic [DATA_W-1:0] d [DEPTH];
  logic              go;
  logic              in_xfer;
  logic              out_xfer;

  assign go       = !stall_i && !flush_i;
  assign adv[DEPTH] = dn.ready;
  assign up.ready = adv[0] && go;
  assign in_xfer  = up.valid && up.ready;
  assign out_xfer = dn.valid && dn.ready && go;

  assign dn.valid = v[DEPTH-1];
  assign dn.ctrl  = c[DEPTH-1];
  assign dn.data  = d[DEPTH-1];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;

    // empty slots always advance, so bubbles collapse
    assign adv[k] = !v[k] || adv[k+1];

    if (k == 0) begin : g_head
      assign s_valid = in_xfer;
      assign s_ctrl  = up.ctrl;
      assign s_data  = up.data;
    end else begin : g_body
      assign s_valid = v[k-1];
      assign s_ctrl  = c[k-1];
      assign s_data  = d[k-1];
    end

    pipe_slot #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (adv[k] && go),
      .clear    (flush_i),
      .src_valid(s_valid),
      .src_ctrl (s_ctrl),
      .src_data (s_data),
      .valid    (v[k]),
      .ctrl     (c[k]),
      .data     (d[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CNT_W'(1);
    end else if (!in_xfer && out_xfer) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule
